// File: rtl/dmem_lsu_if.sv
// Request/response channel between the rv32is pipeline (master) and the
// data-memory load/store unit (slave).
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_op;
  logic              req_we;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_op, req_we, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_op, req_we, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Multi-cycle load/store unit: one request per handshake, sequences the dmem
// read strobe then (for stores) the write strobe. Optional: MISALIGN_TRAP_EN.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   SETUP | dmem address/op/data/we driven, no strobe
//   RCLK  | read strobe high (load data or RMW old word)
//   CAPT  | load data captured into resp_rdata
//   WCLK  | write strobe high, store commits on its rising edge
//   RESP  | response held until resp_ready
module dmem_lsu #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] DMEM_BASE = '0,
  parameter logic [ADDR_W-1:0] DMEM_SIZE = ADDR_W'(32'h0002_0000)
) (
  input  logic        clock,
  input  logic        reset,
  dmem_lsu_if.slave   bus,
  output logic        busy,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemdatain,
  input  logic [31:0] dmemdataout,
  output logic [2:0]  dmemop,
  output logic        dmemwe,
  output logic        dmemrdclk,
  output logic        dmemwrclk
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RCLK  = 3'd2,
    S_CAPT  = 3'd3,
    S_WCLK  = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        busy_q, busy_d;
  logic [31:0] dmemaddr_q, dmemaddr_d;
  logic [31:0] dmemdatain_q, dmemdatain_d;
  logic [2:0]  dmemop_q, dmemop_d;
  logic        dmemwe_q, dmemwe_d;
  logic        rdclk_q, rdclk_d;
  logic        wrclk_q, wrclk_d;

  // Request decode
  logic [ADDR_W:0]   off_ext;
  logic [ADDR_W-1:0] req_off;
  logic              op_bad;
  logic              range_bad;
  logic              misalign_bad;
  logic              req_bad;
  logic              accept;

  // Extra MSB turns the subtraction borrow into the below-base flag.
  assign off_ext = {1'b0, bus.req_addr} - {1'b0, DMEM_BASE};
  assign req_off = off_ext[ADDR_W-1:0];

  always_comb begin
    op_bad    = 1'b0;
    range_bad = 1'b0;
    if ((bus.req_op == 3'b011) || (bus.req_op[2:1] == 2'b11)) begin
      op_bad = 1'b1;
    end
    if (bus.req_op[2] && bus.req_we) begin
      op_bad = 1'b1;
    end
    if (off_ext[ADDR_W] || (req_off >= DMEM_SIZE)) begin
      range_bad = 1'b1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign_bad = 1'b0;
    if ((bus.req_op[1:0] == 2'b01) && bus.req_addr[0]) begin
      misalign_bad = 1'b1;
    end
    if ((bus.req_op[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
      misalign_bad = 1'b1;
    end
  end
`else
  assign misalign_bad = 1'b0;
`endif

  assign req_bad = op_bad | range_bad | misalign_bad;
  assign accept  = bus.req_valid & req_ready_q;

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    dmemaddr_d   = dmemaddr_q;
    dmemdatain_d = dmemdatain_q;
    dmemop_d     = dmemop_q;
    dmemwe_d     = dmemwe_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          resp_rdata_d = '0;
          resp_err_d   = req_bad;
          if (req_bad) begin
            state_d = S_RESP;
          end else begin
            state_d      = S_SETUP;
            dmemaddr_d   = 32'(req_off);
            dmemdatain_d = bus.req_wdata;
            dmemop_d     = bus.req_op;
            dmemwe_d     = bus.req_we;
          end
        end
      end
      S_SETUP: state_d = S_RCLK;
      S_RCLK:  state_d = dmemwe_q ? S_WCLK : S_CAPT;
      S_CAPT: begin
        resp_rdata_d = dmemdataout;
        state_d      = S_RESP;
      end
      S_WCLK:  state_d = S_RESP;
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so every pin comes from a flop.
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    rdclk_d      = (state_d == S_RCLK);
    wrclk_d      = (state_d == S_WCLK);
    if (state_d == S_RESP) begin
      dmemwe_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
      dmemaddr_q   <= '0;
      dmemdatain_q <= '0;
      dmemop_q     <= 3'b010;
      dmemwe_q     <= 1'b0;
      rdclk_q      <= 1'b0;
      wrclk_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      busy_q       <= busy_d;
      dmemaddr_q   <= dmemaddr_d;
      dmemdatain_q <= dmemdatain_d;
      dmemop_q     <= dmemop_d;
      dmemwe_q     <= dmemwe_d;
      rdclk_q      <= rdclk_d;
      wrclk_q      <= wrclk_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign busy           = busy_q;
  assign dmemaddr       = dmemaddr_q;
  assign dmemdatain     = dmemdatain_q;
  assign dmemop         = dmemop_q;
  assign dmemwe         = dmemwe_q;
  assign dmemrdclk      = rdclk_q;
  assign dmemwrclk      = wrclk_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural dmem plus a byte-level reference memory;
// directed cases from the spec followed by randomized traffic.
module tb_dmem_lsu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [31:0] dmemaddr, dmemdatain, dmemdataout;
  logic [2:0]  dmemop;
  logic        dmemwe, dmemrdclk, dmemwrclk;

  dmem_lsu_if #(.ADDR_W(32)) bus ();

  dmem_lsu #(
    .ADDR_W(32), .DMEM_BASE(32'h0), .DMEM_SIZE(32'h0002_0000)
  ) u_dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy),
    .dmemaddr(dmemaddr), .dmemdatain(dmemdatain), .dmemdataout(dmemdataout),
    .dmemop(dmemop), .dmemwe(dmemwe), .dmemrdclk(dmemrdclk), .dmemwrclk(dmemwrclk)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int both_hi  = 0;
  int cyc      = 0;
  int last_acc = 0;
  int prev_acc = 0;

  bit [31:0] mem     [0:32767];
  bit [31:0] ref_mem [0:32767];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset && dmemrdclk && dmemwrclk) both_hi <= both_hi + 1;
  end

  // dmem: read strobe returns extended data, write strobe updates lanes
  logic [31:0] rd_word;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  assign rd_word = mem[dmemaddr[16:2]];
  assign rd_b    = rd_word[{dmemaddr[1:0], 3'b000} +: 8];
  assign rd_h    = dmemaddr[1] ? rd_word[31:16] : rd_word[15:0];

  always @(posedge dmemrdclk) begin
    rd_cnt <= rd_cnt + 1;
    case (dmemop)
      3'b000:  dmemdataout <= {{24{rd_b[7]}}, rd_b};
      3'b001:  dmemdataout <= {{16{rd_h[15]}}, rd_h};
      3'b100:  dmemdataout <= {24'h0, rd_b};
      3'b101:  dmemdataout <= {16'h0, rd_h};
      default: dmemdataout <= rd_word;
    endcase
  end

  always @(posedge dmemwrclk) begin
    wr_cnt <= wr_cnt + 1;
    if (dmemwe) begin
      case (dmemop[1:0])
        2'b00: mem[dmemaddr[16:2]][{dmemaddr[1:0], 3'b000} +: 8] <= dmemdatain[7:0];
        2'b01: begin
          if (dmemaddr[1]) mem[dmemaddr[16:2]][31:16] <= dmemdatain[15:0];
          else             mem[dmemaddr[16:2]][15:0]  <= dmemdatain[15:0];
        end
        default: mem[dmemaddr[16:2]] <= dmemdatain;
      endcase
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on byte addresses
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] word;
    logic [31:0] b;
    logic [31:0] h;
    word = ref_mem[a[16:2]];
    b = (word >> (8 * (a % 4))) & 32'hFF;
    h = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op);
    logic [31:0] mask;
    logic [31:0] sh;
    if (op == 3'd0) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
    end else if (op == 3'd1) begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    ref_mem[a[16:2]] = (ref_mem[a[16:2]] & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic [2:0] op, input logic we);
    logic e;
    e = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
    e = e || (we && (op == 3'd4 || op == 3'd5));
    e = e || (a >= 32'h0002_0000);
`ifdef MISALIGN_TRAP_EN
    e = e || ((op == 3'd1 || op == 3'd5) && (a % 2 != 0));
    e = e || ((op == 3'd2) && (a % 4 != 0));
`endif
    return e;
  endfunction

  task automatic start_req(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                           input logic we, output int acc);
    int n;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_op    = op;
    bus.req_we    = we;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) chk_eq("accept_timeout", 32'(0), 32'(1));
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    acc = cyc;
  endtask

  // Ends on the handshake edge; lat counts edges from the accept edge.
  task automatic wait_resp(output logic [31:0] rdata, output logic err, output int lat);
    bit got;
    got = 0;
    lat = 0;
    rdata = '0;
    err = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (bus.resp_valid) begin
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        got   = 1;
      end
      @(posedge clock);
      lat++;
    end
    if (!got) chk_eq("resp_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] op, input logic we);
    logic        exp_err, got_err;
    logic [31:0] exp_rd, got_rd;
    int          acc, lat, rd0, wr0;
    exp_err = ref_err(a, op, we);
    exp_rd  = (exp_err || we) ? 32'h0 : ref_load(a, op);
    start_req(a, wd, op, we, acc);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    wait_resp(got_rd, got_err, lat);
    #1;
    chk_eq({tag, "_err"},   32'(got_err), 32'(exp_err));
    chk_eq({tag, "_rdata"}, got_rd, exp_rd);
    chk_eq({tag, "_lat"},   32'(lat), exp_err ? 32'(1) : 32'(4));
    chk_eq({tag, "_rdclk"}, 32'(rd_cnt - rd0), exp_err ? 32'(0) : 32'(1));
    chk_eq({tag, "_wrclk"}, 32'(wr_cnt - wr0), (!exp_err && we) ? 32'(1) : 32'(0));
    chk_eq({tag, "_rv_clr"}, 32'(bus.resp_valid), 32'(0));
    if (!exp_err && we) ref_store(a, wd, op);
    prev_acc = last_acc;
    last_acc = acc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  logic [2:0] rand_ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};

  initial begin
    logic [31:0] exp_hold, got_rd, a, wd;
    logic        got_err;
    logic [2:0]  op;
    logic        we;
    int          lat, hs, acc2, wr0, n;

    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_op     = 3'd2;
    bus.req_we     = 1'b0;
    bus.resp_ready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    chk_eq("rst_req_ready",  32'(bus.req_ready), 32'(1));
    chk_eq("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
    chk_eq("rst_resp_err",   32'(bus.resp_err), 32'(0));
    chk_eq("rst_rdata",      bus.resp_rdata, 32'h0);
    chk_eq("rst_busy",       32'(busy), 32'(0));
    chk_eq("rst_strobes",    {29'h0, dmemwe, dmemrdclk, dmemwrclk}, 32'h0);
    chk_eq("rst_dmemaddr",   dmemaddr, 32'h0);
    chk_eq("rst_datain",     dmemdatain, 32'h0);
    chk_eq("rst_dmemop",     32'(dmemop), 32'(3'b010));
    @(negedge clock);
    reset = 1'b1;

    do_txn("sw_w0",  32'h0, 32'h0BAD_F00D, 3'd2, 1'b1);
    do_txn("sw_w4",  32'h10, 32'hDEAD_BEEF, 3'd2, 1'b1);
    do_txn("lw_w4",  32'h10, 32'h0, 3'd2, 1'b0);
    do_txn("sw_pre", 32'h10, 32'h1122_3344, 3'd2, 1'b1);
    do_txn("sb_13",  32'h13, 32'h0000_00A5, 3'd0, 1'b1);
    do_txn("lw_10",  32'h10, 32'h0, 3'd2, 1'b0);
    chk_eq("sb_readback", ref_mem[4], 32'hA522_3344);
    do_txn("lb_13",  32'h13, 32'h0, 3'd0, 1'b0);
    do_txn("lbu_13", 32'h13, 32'h0, 3'd4, 1'b0);
    chk_eq("thru_5", 32'(last_acc - prev_acc), 32'(5));
    do_txn("lh_12",  32'h12, 32'h0, 3'd1, 1'b0);
    do_txn("op7",    32'h20, 32'h0, 3'd7, 1'b0);
    do_txn("oor",    32'h0002_0000, 32'h0, 3'd2, 1'b0);
    do_txn("lastw",  32'h0001_FFFC, 32'h0, 3'd2, 1'b0);
    do_txn("sbu",    32'h20, 32'h55, 3'd4, 1'b1);
    do_txn("op3",    32'h20, 32'h0, 3'd3, 1'b0);
    do_txn("mis_lw", 32'h2, 32'h0, 3'd2, 1'b0);

    // Response back-pressure with a second request already waiting
    exp_hold = ref_load(32'h10, 3'd2);
    @(negedge clock);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h10;
    bus.req_op     = 3'd2;
    bus.req_we     = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    bus.req_addr = 32'h12;
    bus.req_op   = 3'd5;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      chk_eq("hold_rv",    32'(bus.resp_valid), 32'(1));
      chk_eq("hold_rdata", bus.resp_rdata, exp_hold);
      chk_eq("hold_ready", 32'(bus.req_ready), 32'(0));
      @(negedge clock);
    end
    bus.resp_ready = 1'b1;
    @(posedge clock);
    #1;
    hs = cyc;
    @(negedge clock);
    chk_eq("hs_ready", 32'(bus.req_ready), 32'(1));
    chk_eq("hs_rv",    32'(bus.resp_valid), 32'(0));
    @(posedge clock);
    #1;
    acc2 = cyc;
    bus.req_valid = 1'b0;
    chk_eq("b2b_accept", 32'(acc2 - hs), 32'(1));
    chk_eq("b2b_busy",   32'(busy), 32'(1));
    wait_resp(got_rd, got_err, lat);
    chk_eq("b2b_rdata", got_rd, ref_load(32'h12, 3'd5));
    chk_eq("b2b_lat",   32'(lat), 32'(4));

    // Reset while the write strobe is high: store already committed
    start_req(32'h80, 32'hCAFE_F00D, 3'd2, 1'b1, n);
    n = 0;
    while (!dmemwrclk && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk_eq("abw_seen", 32'(dmemwrclk), 32'(1));
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_eq("abw_busy",  32'(busy), 32'(0));
    chk_eq("abw_rv",    32'(bus.resp_valid), 32'(0));
    chk_eq("abw_wrclk", 32'(dmemwrclk), 32'(0));
    chk_eq("abw_ready", 32'(bus.req_ready), 32'(1));
    ref_store(32'h80, 32'hCAFE_F00D, 3'd2);
    chk_eq("abw_mem", mem[32], ref_mem[32]);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk_eq("abw_no_resp", 32'(bus.resp_valid), 32'(0));
    end

    // Reset while the read strobe is high: store never happens
    start_req(32'h80, 32'h1234_5678, 3'd2, 1'b1, n);
    wr0 = wr_cnt;
    n = 0;
    while (!dmemrdclk && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk_eq("abr_seen", 32'(dmemrdclk), 32'(1));
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_eq("abr_busy", 32'(busy), 32'(0));
    chk_eq("abr_rv",   32'(bus.resp_valid), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk_eq("abr_no_wr", 32'(wr_cnt - wr0), 32'(0));
    chk_eq("abr_no_resp", 32'(bus.resp_valid), 32'(0));
    do_txn("abr_lw", 32'h80, 32'h0, 3'd2, 1'b0);

    for (int t = 0; t < 80; t++) begin
      op = rand_ops[$urandom_range(0, 7)];
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = 32'h0002_0000 + 32'($urandom_range(0, 63)) * 4;
        1:       a = 32'hFFFF_FFF0;
        default: begin
          a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
          if (op[1:0] == 2'b01) a = a & ~32'h1;
          if (op[1:0] == 2'b10) a = a & ~32'h3;
        end
      endcase
      do_txn("rnd", a, wd, op, we);
    end

    chk_eq("strobe_excl", 32'(both_hi), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
